div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle sequencer for the integer divide unit behind DIV/DIVU. It latches operands when the decoder's div strobe reaches EX and runs a restoring shift-subtract loop, one quotient bit per cycle. It stalls the pipeline while the loop runs, then delivers a single HI/LO write. It sits in EX beside the ALU and feeds the HI/LO register file alongside the MULT path.

## Interface
Clocking is decided: one clock, and reset is synchronous and active-high.

Parameters:
- WIDTH, 32, operand width; the loop runs WIDTH iterations.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- div_start  in  1  decoder div strobe for the instruction in EX.
- div_signed  in  1  decoder hassign; 1 = DIV, 0 = DIVU.
- opa  in  WIDTH  dividend (rs).
- opb  in  WIDTH  divisor (rt).
- annul  in  1  flush/exception kill of the EX instruction.
- div_stall  out  1  holds IF/ID/EX while the divide is in progress.
- div_busy  out  1  sequencer is not IDLE.
- hilo_we  out  2  2'b11 = write HI and LO, 2'b10 = no write (same encoding as hilo_en).
- hi_out  out  WIDTH  remainder.
- lo_out  out  WIDTH  quotient.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, with div_start=1 and annul=0:
  - latch magnitudes |opa| and |opb| (magnitude taken only if div_signed=1), plus the sign flags and div_signed;
  - clear the 2·WIDTH working register {rem, quo} = {0, |opa|};
  - set count = 0 and go to CALC.
- CALC, each cycle:
  - shift {rem, quo} left by 1;
  - trial = rem − divisor, computed at WIDTH+1 bits;
  - if there is no borrow, rem = trial and quo[0] = 1.
  - count increments; after iteration WIDTH−1 go to FIX.
- FIX applies the sign rules:
  - quotient is negated if signed and opa[31]^opb[31];
  - remainder is negated if signed and opa[31].
  - Then go to DONE.
- DONE: hilo_we = 2'b11 and hi_out/lo_out are valid for exactly this cycle; then go to IDLE.
- Divide by zero: the result is hi_out = opa (raw) and lo_out = all ones, regardless of div_signed. The sign fixup is suppressed.
- 0x80000000 / −1 (signed): lo_out = 0x80000000, hi_out = 0. This falls out naturally from the unsigned magnitudes.
- annul:
  - In CALC or FIX, the next state is IDLE and hilo_we never asserts.
  - In DONE, annul forces hilo_we = 2'b10.
  - In IDLE, annul blocks the start.
- div_start is ignored outside IDLE.
- Outputs: hi_out/lo_out hold their last value outside DONE. hilo_we = 2'b10 outside DONE.

## Timing
- Cycle 0 is the cycle where IDLE sees div_start.
- div_stall = (IDLE & div_start & ~annul) | CALC | FIX. It is combinational from div_start.
- Full divide:
  - CALC occupies cycles 1..WIDTH and FIX is cycle WIDTH+1;
  - DONE is cycle WIDTH+2, with div_stall = 0 so the DIV instruction retires;
  - total stall is WIDTH+2 cycles (34 for WIDTH=32).
- After DONE the state is IDLE. A new divide may start on the very next cycle.
- Annul in cycle k (CALC/FIX): div_busy = 0 in cycle k+1, and a new start is accepted in cycle k+1.
- Reset state and values:
  - state IDLE, count 0;
  - div_stall 0, div_busy 0;
  - hilo_we 2'b10, hi_out 0, lo_out 0.
- Reset mid-operation discards the divide with no write.

## Configuration
- DIV_ZERO_FAST_EN
  - Defined: in IDLE, opb == 0 jumps straight to DONE. The stall lasts 1 cycle and the result is in cycle 1.
  - Undefined: divide by zero runs the full WIDTH+2 cycles.
  - Result values, annul behaviour and reset behaviour are identical in both builds.

## Structure
- Shared package holds:
  - the state enum (IDLE/CALC/FIX/DONE);
  - the HILO_NONE = 2'b10 and HILO_BOTH = 2'b11 constants, shared with the decoder;
  - the default DIV_WIDTH = 32.
- One combinational sub-module, div_step: input {rem, quo} and divisor; output the next {rem, quo}.
- Counter, FSM and sign fixup live in div_sequencer.

## Test plan
- DIVU 100/7: start at cycle 0 → div_stall high in cycles 0–33; cycle 34 has hilo_we = 11, lo = 14, hi = 2.
- DIV −7/2 (0xFFFFFFF9 / 2) → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 7/−2 → lo = 0xFFFFFFFD, hi = 1.
- DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0, no hang.
- DIV 5/0:
  - both builds give hi = 5, lo = 0xFFFFFFFF;
  - DONE at cycle 34 without DIV_ZERO_FAST_EN, at cycle 1 with it.
- Annul at cycle 10 → div_busy = 0 at cycle 11; no hilo_we ever; a start at cycle 11 yields the correct result at cycle 45.
- Separately, rst at cycle 20 → all outputs at reset values at cycle 21; div_start held high outside IDLE causes no relaunch; back-to-back divides: second start in the cycle after DONE.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// Shared constants for the divide sequencer and the decoder's HI/LO enables.
// State codes are plain localparams so legacy tools can read them.
package div_sequencer_pkg;

   localparam int DIV_WIDTH = 32;

   localparam logic [1:0] HILO_NONE = 2'b10;
   localparam logic [1:0] HILO_BOTH = 2'b11;

   typedef logic [1:0] div_state_t;

   localparam div_state_t ST_IDLE = 2'd0;
   localparam div_state_t ST_CALC = 2'd1;
   localparam div_state_t ST_FIX  = 2'd2;
   localparam div_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/div_sequencer_step.sv
// One restoring shift-subtract iteration on the {rem, quo} working register.
// The shifted remainder keeps its carry-out bit so the trial never overflows.
module div_step
   import div_sequencer_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [2*WIDTH-1:0] rq_in,
   input  logic [WIDTH-1:0]   divisor,
   output logic [2*WIDTH-1:0] rq_out
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;
   logic           borrow;

   // shift left, trial subtract, keep the difference when it does not borrow
   always_comb begin
      shifted = rq_in[2*WIDTH-1:WIDTH-1];
      trial   = shifted - {1'b0, divisor};
      borrow  = trial[WIDTH];
      rq_out  = {borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0],
                 rq_in[WIDTH-2:0], ~borrow};
   end

endmodule

// File: rtl/div_sequencer.sv
// DIV/DIVU sequencer: magnitude divide, sign fixup, single HI/LO write.
// Build option DIV_ZERO_FAST_EN: divide by zero skips the loop.
module div_sequencer
   import div_sequencer_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_start,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             annul,
   output logic             div_stall,
   output logic             div_busy,
   output logic [1:0]       hilo_we,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   div_state_t         state;
   div_state_t         state_nxt;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] rq;
   logic [2*WIDTH-1:0] rq_step;
   logic [WIDTH-1:0]   divisor;
   logic               neg_q;
   logic               neg_r;
   logic               dz;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   q_fix;
   logic [WIDTH-1:0]   r_fix;
   logic               start_ok;
   logic               fast_dz;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rq_in   (rq),
      .divisor (divisor),
      .rq_out  (rq_step)
   );

   // operand magnitudes, accepted start and sign-corrected results
   always_comb begin
      mag_a    = (div_signed && opa[WIDTH-1]) ? -opa : opa;
      mag_b    = (div_signed && opb[WIDTH-1]) ? -opb : opb;
      start_ok = (state == ST_IDLE) && div_start && !annul;
`ifdef DIV_ZERO_FAST_EN
      fast_dz  = (opb == '0);
`else
      fast_dz  = 1'b0;
`endif
      // with a zero divisor the loop leaves |opa| in rem, so the normal
      // remainder negation restores the raw dividend; quotient is forced
      q_fix    = dz ? '1 : (neg_q ? -rq[WIDTH-1:0] : rq[WIDTH-1:0]);
      r_fix    = neg_r ? -rq[2*WIDTH-1:WIDTH] : rq[2*WIDTH-1:WIDTH];
   end

   // next-state: annul kills an in-flight divide without a write
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (start_ok) state_nxt = fast_dz ? ST_DONE : ST_CALC;
         ST_CALC: begin
            if (annul)              state_nxt = ST_IDLE;
            else if (count == LAST) state_nxt = ST_FIX;
         end
         ST_FIX:  state_nxt = annul ? ST_IDLE : ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // state, operand latch, iteration and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         count   <= '0;
         rq      <= '0;
         divisor <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         dz      <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state <= state_nxt;
         if (start_ok) begin
            rq      <= {{WIDTH{1'b0}}, mag_a};
            divisor <= mag_b;
            neg_q   <= div_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
            neg_r   <= div_signed & opa[WIDTH-1];
            dz      <= (opb == '0);
            count   <= '0;
            if (fast_dz) begin
               hi_q <= opa;
               lo_q <= '1;
            end
         end
         if (state == ST_CALC) begin
            rq    <= rq_step;
            count <= count + 1'b1;
         end
         if (state == ST_FIX && !annul) begin
            hi_q <= r_fix;
            lo_q <= q_fix;
         end
      end
   end

   // pipeline handshake outputs
   always_comb begin
      div_busy  = (state != ST_IDLE);
      div_stall = start_ok || (state == ST_CALC) || (state == ST_FIX);
      hilo_we   = (state == ST_DONE && !annul) ? HILO_BOTH : HILO_NONE;
      hi_out    = hi_q;
      lo_out    = lo_q;
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a result scoreboard.
// Define DIV_ZERO_FAST_EN for both RTL and bench to test the fast build.
module tb_div_sequencer;
   import div_sequencer_pkg::*;

   logic        clk;
   logic        rst;
   logic        div_start;
   logic        div_signed;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        annul;
   logic        div_stall;
   logic        div_busy;
   logic [1:0]  hilo_we;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          at;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   div_sequencer #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .div_start  (div_start),
      .div_signed (div_signed),
      .opa        (opa),
      .opb        (opb),
      .annul      (annul),
      .div_stall  (div_stall),
      .div_busy   (div_busy),
      .hilo_we    (hilo_we),
      .hi_out     (hi_out),
      .lo_out     (lo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // monitor: every HI/LO write must match the oldest expected result
   always @(negedge clk) begin
      if (!rst && hilo_we === HILO_BOTH) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got hi=%h lo=%h expected none",
                     hi_out, lo_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("hi", hi_out, e.hi);
            chk("lo", lo_out, e.lo);
            chk("done_cycle", 32'(cyc), 32'(e.at));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(string nm);
      chk({nm, "_stall"}, 32'(div_stall), 32'd0);
      chk({nm, "_busy"}, 32'(div_busy), 32'd0);
      chk({nm, "_hilo_we"}, 32'(hilo_we), 32'(HILO_NONE));
      chk({nm, "_hi"}, hi_out, 32'd0);
      chk({nm, "_lo"}, lo_out, 32'd0);
   endtask

   // called #1 after a rising edge; returns #1 after the edge following DONE
   task automatic run_div(input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic hold,
                          input string nm);
      int lat;
      int t0;
      int n_st;
      bit seen;
      lat = 34;
`ifdef DIV_ZERO_FAST_EN
      if (b == 32'd0) lat = 1;
`endif
      t0 = cyc;
      div_start  = 1'b1;
      div_signed = sgn;
      opa        = a;
      opb        = b;
      sb.push_back('{ehi, elo, t0 + lat});
      n_st = 0;
      seen = 0;
      for (int i = 0; i < 80 && !seen; i++) begin
         @(negedge clk);
         if (div_stall) n_st++;
         if (hilo_we === HILO_BOTH) seen = 1;
         else begin
            tick();
            div_start = hold;
         end
      end
      div_start = 1'b0;
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: got no write expected write", nm);
      end else begin
         chk({nm, "_stall_cycles"}, 32'(n_st), 32'(lat));
      end
      tick();
   endtask

   initial begin
      rst        = 1'b1;
      div_start  = 1'b0;
      div_signed = 1'b0;
      opa        = '0;
      opb        = '0;
      annul      = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      check_reset_vals("reset");

      // back-to-back divides, each started the cycle after the previous DONE
      run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_100_7");
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
              1'b0, "div_m7_2");
      run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD,
              1'b0, "div_7_m2");
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000,
              1'b0, "div_min_m1");
      run_div(1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0, "div_5_0");
      run_div(1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0, "divu_5_0");
      run_div(1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
              1'b0, "div_m7_0");

      // start held high through the loop must not relaunch
      run_div(1'b0, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF,
              1'b1, "divu_hold");
      chk("hold_idle_busy", 32'(div_busy), 32'd0);

      // annul in cycle 10, restart in cycle 11
      div_start  = 1'b1;
      div_signed = 1'b0;
      opa        = 32'd1000;
      opb        = 32'd3;
      for (int k = 1; k <= 10; k++) begin
         tick();
         div_start = 1'b0;
      end
      annul = 1'b1;
      @(negedge clk);
      chk("annul_busy_c10", 32'(div_busy), 32'd1);
      tick();
      annul = 1'b0;
      chk("annul_busy_c11", 32'(div_busy), 32'd0);
      run_div(1'b0, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, "after_annul");

      // annul during DONE suppresses the write
      div_start = 1'b1;
      opa       = 32'd9;
      opb       = 32'd3;
      for (int k = 1; k <= 34; k++) begin
         tick();
         div_start = 1'b0;
      end
      annul = 1'b1;
      @(negedge clk);
      chk("annul_done_we", 32'(hilo_we), 32'(HILO_NONE));
      tick();
      annul = 1'b0;
      chk("annul_done_busy", 32'(div_busy), 32'd0);

      // reset in cycle 20 of a divide
      div_start = 1'b1;
      opa       = 32'd50;
      opb       = 32'd5;
      for (int k = 1; k <= 20; k++) begin
         tick();
         div_start = 1'b0;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_vals("midrst");
      run_div(1'b0, 32'd12345, 32'd100, 32'd45, 32'd123, 1'b0, "after_rst");

      repeat (5) tick();
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
